// File: rtl/node_start_initiator.sv
// Initiator side of the ST/RD node handshake: starts NCHILD children, waits for RD low-then-high, captures RES.
// Optional watchdog per wait phase enabled by defining NODE_INIT_TIMEOUT_EN (default build: no watchdog, ERR tied 0).
module node_start_initiator #(
    parameter int WIDTH  = 16,
    parameter int NCHILD = 2,
    parameter int TMO_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     go_i,
    output logic [NCHILD-1:0]        st_o,
    input  logic [NCHILD-1:0]        rd_in_i,
    input  logic [NCHILD*WIDTH-1:0]  res_in_i,
    output logic [NCHILD*WIDTH-1:0]  ops_o,
    output logic                     done_o,
    output logic                     err_o
);

    if (NCHILD < 1 || NCHILD > 8 || TMO_W < 1) begin : g_bad_cfg
        $error("node_start_initiator: NCHILD must be 1..8 and TMO_W >= 1");
    end

    typedef enum logic [2:0] {IDLE, ARM, DROP, RISE, CAPT} state_e;

    state_e                    state_q, state_d;
    logic [NCHILD-1:0]         st_q, st_d;
    logic [NCHILD-1:0]         seen_q, seen_d;
    logic [NCHILD*WIDTH-1:0]   ops_q, ops_d;
    logic                      done_q, done_d;
    logic                      go_old_q;
    logic                      start, rd_all, seen_all, tmo_hit;

    assign start    = go_i & ~go_old_q;
    assign rd_all   = &rd_in_i;
    // A child counts as finished only after its RD was seen low, so a stale RD=1 is never taken as completion.
    assign seen_all = &(seen_q | ~rd_in_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            st_q     <= '0;
            seen_q   <= '0;
            ops_q    <= '0;
            done_q   <= 1'b1;
            go_old_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            seen_q   <= seen_d;
            ops_q    <= ops_d;
            done_q   <= done_d;
            go_old_q <= go_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = ARM;
            ARM:     if (rd_all)   state_d = DROP;
            DROP:    if (seen_all) state_d = RISE;
            RISE:    if (rd_all)   state_d = CAPT;
            CAPT:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_comb begin
        st_d   = st_q;
        seen_d = seen_q;
        ops_d  = ops_q;
        done_d = done_q;
        case (state_q)
            IDLE: begin
                seen_d = '0;
                if (start) done_d = 1'b0;
            end
            ARM:  if (rd_all) st_d = '1;
            DROP: begin
                seen_d = seen_q | ~rd_in_i;
                if (seen_all) st_d = '0;
            end
            CAPT: begin
                ops_d  = res_in_i;
                done_d = 1'b1;
            end
            default: ;
        endcase
        // Watchdog abort leaves OPS untouched and hands control back upstream.
        if (tmo_hit) begin
            st_d   = '0;
            done_d = 1'b1;
        end
    end

`ifdef NODE_INIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, waiting;

    assign waiting = (state_q == ARM) || (state_q == DROP) || (state_q == RISE);
    assign tmo_hit = waiting && (tmo_q == {TMO_W{1'b1}});

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) tmo_d = '0;
        else if (waiting)       tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_q | tmo_hit;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign st_o   = st_q;
    assign ops_o  = ops_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_node_start_initiator.sv
// Scoreboard bench for node_start_initiator: two behavioural children, expected DONE events queued per run.
module tb_node_start_initiator;

    localparam int WIDTH  = 16;
    localparam int NCHILD = 2;
    localparam int TMO_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    go  = 1'b0;
    logic [NCHILD-1:0]       st;
    logic [NCHILD-1:0]       rd  = '1;
    logic [WIDTH-1:0]        res0 = '0, res1 = '0;
    logic [NCHILD*WIDTH-1:0] ops;
    logic                    done, err;

    node_start_initiator #(.WIDTH(WIDTH), .NCHILD(NCHILD), .TMO_W(TMO_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .go_i    (go),
        .st_o    (st),
        .rd_in_i (rd),
        .res_in_i({res1, res0}),
        .ops_o   (ops),
        .done_o  (done),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] ops;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Child model: after seeing ST rise, waits dly cycles, drops RD for lo cycles, then raises it.
    int          dly[NCHILD];
    int          lo[NCHILD];
    bit          stuck[NCHILD];
    int          dcnt[NCHILD];
    int          lcnt[NCHILD];
    logic [NCHILD-1:0] st_prev = '0;

    always @(negedge clk) begin
        for (int i = 0; i < NCHILD; i++) begin
            if (stuck[i]) begin
                rd[i] = 1'b1; dcnt[i] = 0; lcnt[i] = 0;
            end else if (st[i] && !st_prev[i]) begin
                if (dly[i] == 0) begin rd[i] = 1'b0; lcnt[i] = lo[i]; end
                else dcnt[i] = dly[i];
            end else if (dcnt[i] > 0) begin
                dcnt[i]--;
                if (dcnt[i] == 0) begin rd[i] = 1'b0; lcnt[i] = lo[i]; end
            end else if (lcnt[i] > 0) begin
                lcnt[i]--;
                if (lcnt[i] == 0) rd[i] = 1'b1;
            end
        end
        st_prev = st;
    end

    // Monitor: every DONE rising edge outside reset must match the oldest queued run.
    logic done_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst && done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_ops", {32'd0, ops}, {32'd0, e.ops});
                check("mon_err", {63'd0, err}, {63'd0, e.err});
                check("mon_latency_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
        done_prev = done;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a negedge: raises GO and queues the expected completion.
    task automatic launch(input logic [31:0] eops, input logic eerr, input int lat);
        exp_t e;
        go    = 1'b1;
        e.ops = eops;
        e.err = eerr;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        tick(2);
    endtask

    task automatic set_child(input int d0, input int d1);
        dly[0] = d0; dly[1] = d1;
        lo[0]  = 2;  lo[1]  = 2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        set_child(1, 1);
        stuck[0] = 1'b0; stuck[1] = 1'b0;

        // Reset values while held in reset.
        tick(2);
        check("rst_st",   {62'd0, st},   64'd0);
        check("rst_done", {63'd0, done}, 64'd1);
        check("rst_err",  {63'd0, err},  64'd0);
        check("rst_ops",  {32'd0, ops},  64'd0);
        rst = 1'b0;
        tick(2);

        // Basic run: ST held until both RD low, OPS = {ABCD,1234} six cycles after GO edge.
        res0 = 16'h1234; res1 = 16'hABCD;
        launch(32'hABCD_1234, 1'b0, 6);
        tick(1); go = 1'b0;
        tick(2);
        check("basic_st_high", {62'd0, st}, 64'd3);
        tick(1);
        check("basic_st_low", {62'd0, st}, 64'd0);
        wait_sb("basic");

        // Asynchronous reset mid-DROP, checked without a clock edge.
        launch(32'h0, 1'b0, 0);
        tick(1); go = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("arst_st",   {62'd0, st},   64'd0);
        check("arst_done", {63'd0, done}, 64'd1);
        check("arst_err",  {63'd0, err},  64'd0);
        check("arst_ops",  {32'd0, ops},  64'd0);
        sb.delete();
        tick(4);
        rst = 1'b0;
        tick(4);

        // Skew: child1 drops 3 cycles after child0; ST held until both seen low.
        set_child(1, 4);
        res0 = 16'h5555; res1 = 16'h0F0F;
        launch(32'h0F0F_5555, 1'b0, 9);
        tick(1); go = 1'b0;
        tick(5);
        check("skew_st_held", {62'd0, st}, 64'd3);
        tick(1);
        check("skew_st_low", {62'd0, st}, 64'd0);
        wait_sb("skew");

        // Stale RD: child0 keeps RD high two cycles after ST rise.
        set_child(2, 1);
        res0 = 16'h0001; res1 = 16'h8000;
        launch(32'h8000_0001, 1'b0, 7);
        tick(1); go = 1'b0;
        tick(4);
        check("stale_not_done", {63'd0, done}, 64'd0);
        wait_sb("stale");

        // GO held high across completion: exactly one run.
        set_child(1, 1);
        res0 = 16'hBEEF; res1 = 16'hCAFE;
        launch(32'hCAFE_BEEF, 1'b0, 6);
        tick(14);
        go = 1'b0;
        tick(3);
        check("hold_one_run", 64'(sb.size()), 64'd0);
        check("hold_done", {63'd0, done}, 64'd1);
        wait_sb("hold");

        // GO re-pulsed while busy: ignored, one run only.
        res0 = 16'h1111; res1 = 16'h2222;
        launch(32'h2222_1111, 1'b0, 6);
        tick(1); go = 1'b0;
        tick(1); go = 1'b1;
        tick(12);
        go = 1'b0;
        tick(3);
        check("repulse_one_run", 64'(sb.size()), 64'd0);
        check("repulse_ops", {32'd0, ops}, 64'h2222_1111);
        wait_sb("repulse");

        // Child1 RD stuck high during DROP.
        stuck[1] = 1'b1;
        res0 = 16'h7777; res1 = 16'h6666;
`ifdef NODE_INIT_TIMEOUT_EN
        launch(32'h2222_1111, 1'b1, 17);
        tick(1); go = 1'b0;
        wait_sb("tmo");
        check("tmo_st", {62'd0, st}, 64'd0);
        check("tmo_err", {63'd0, err}, 64'd1);
        stuck[1] = 1'b0;
        tick(2);
        // A new run does not clear the sticky error.
        launch(32'h6666_7777, 1'b1, 6);
        tick(1); go = 1'b0;
        wait_sb("after_tmo");
`else
        go = 1'b1;
        tick(1); go = 1'b0;
        tick(40);
        check("stuck_done", {63'd0, done}, 64'd0);
        check("stuck_err",  {63'd0, err},  64'd0);
        check("stuck_st",   {62'd0, st},   64'd3);
        stuck[1] = 1'b0;
`endif
        do_reset();
        check("final_err",  {63'd0, err},  64'd0);
        check("final_done", {63'd0, done}, 64'd1);
        check("final_ops",  {32'd0, ops},  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
